// File: rtl/l2sw_pkg.sv
// Shared L2 switch definitions: header geometry, arbiter state encoding and index-width helper.
package l2sw_pkg;

  localparam int unsigned HEADER_DWIDTH = 128;
  localparam int unsigned CTRL_BIT      = 114;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Bits needed to index nports ports (at least one bit).
  function automatic int unsigned port_idx_w(input int unsigned nports);
    return (nports <= 2) ? 1 : $clog2(nports);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority picker: first set bit of req scanning ptr, ptr+1, ... (mod NREQ).
module rr_arb_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk the request vector starting at ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-atomic round-robin arbiter presenting one of NPORTS ingress header/body FIFO pairs
// to a single consumer as a virtual FIFO pair. Grant is held until the header pop.
// Optional feature: define CTRL_PRIO_EN to let ports with a control-frame header
// (header bit CTRL_BIT set) win arbitration ahead of normal ports.
module ingress_frame_arbiter #(
  parameter int unsigned NPORTS        = 4,
  parameter int unsigned HEADER_DWIDTH = l2sw_pkg::HEADER_DWIDTH,
  parameter int unsigned CTRL_BIT      = l2sw_pkg::CTRL_BIT
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic [NPORTS*HEADER_DWIDTH-1:0]        h_fifo_dout,
  input  logic [NPORTS-1:0]                      h_fifo_empty,
  output logic [NPORTS-1:0]                      h_fifo_rden,
  input  logic [NPORTS*8-1:0]                    b_fifo_dout,
  input  logic [NPORTS-1:0]                      b_fifo_empty,
  input  logic [NPORTS-1:0]                      b_fifo_del,
  output logic [NPORTS-1:0]                      b_fifo_rden,
  output logic [HEADER_DWIDTH-1:0]               m_h_dout,
  output logic                                   m_h_empty,
  input  logic                                   m_h_rden,
  output logic [7:0]                             m_b_dout,
  output logic                                   m_b_empty,
  output logic                                   m_b_del,
  input  logic                                   m_b_rden,
  output logic                                   grant_valid,
  output logic [l2sw_pkg::port_idx_w(NPORTS)-1:0] grant_port
);

  import l2sw_pkg::*;

  localparam int unsigned PW = port_idx_w(NPORTS);

  // Elaboration-time sanity checks on the configuration.
  if (NPORTS < 2 || NPORTS > 8) begin : g_bad_nports
    $error("ingress_frame_arbiter: NPORTS must be 2..8");
  end
  if (CTRL_BIT >= HEADER_DWIDTH) begin : g_bad_ctrl_bit
    $error("ingress_frame_arbiter: CTRL_BIT outside header word");
  end

  arb_state_e          state_q, state_d;
  logic                grant_valid_q, grant_valid_d;
  logic [PW-1:0]       grant_port_q, grant_port_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NPORTS-1:0]   req;
  logic [NPORTS-1:0]   pick_req;
  logic [PW-1:0]       pick_idx;
  logic                pick_found;

  assign req = ~h_fifo_empty;

`ifdef CTRL_PRIO_EN
  logic [NPORTS-1:0]   ctrl_req;

  // Requesting ports whose head header is a control frame.
  for (genvar i = 0; i < NPORTS; i++) begin : g_ctrl
    assign ctrl_req[i] = req[i] & h_fifo_dout[i*HEADER_DWIDTH + CTRL_BIT];
  end

  // Control frames, when present, are the only contenders.
  assign pick_req = (|ctrl_req) ? ctrl_req : req;
`else
  assign pick_req = req;
`endif

  rr_arb_pick #(
    .NREQ  (NPORTS),
    .IDX_W (PW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state: grant in IDLE, hold through BUSY until header pop, one GAP cycle after.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_port_d  = grant_port_q;
    rr_ptr_d      = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_port_d  = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_h_rden) begin
          rr_ptr_d      = (grant_port_q == PW'(NPORTS - 1)) ? '0 : grant_port_q + PW'(1);
          grant_valid_d = 1'b0;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and grant registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_port_q  <= '0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_port_q  <= grant_port_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Virtual FIFO mux and pop steering; idle values whenever no frame is granted.
  always_comb begin
    h_fifo_rden = '0;
    b_fifo_rden = '0;
    m_h_dout    = '0;
    m_h_empty   = 1'b1;
    m_b_dout    = '0;
    m_b_empty   = 1'b1;
    m_b_del     = 1'b0;
    if (state_q == ST_BUSY) begin
      m_h_dout                  = h_fifo_dout[grant_port_q*HEADER_DWIDTH +: HEADER_DWIDTH];
      m_h_empty                 = h_fifo_empty[grant_port_q];
      m_b_dout                  = b_fifo_dout[grant_port_q*8 +: 8];
      m_b_empty                 = b_fifo_empty[grant_port_q];
      m_b_del                   = b_fifo_del[grant_port_q];
      h_fifo_rden[grant_port_q] = m_h_rden;
      b_fifo_rden[grant_port_q] = m_b_rden;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_port  = grant_port_q;

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Bench for ingress_frame_arbiter: queue-based FIFO/port model, random consumer, directed scenarios.
module tb_ingress_frame_arbiter;

  localparam int NP = 4;
  localparam int HW = 128;
  localparam int CB = 114;
  localparam int PW = 2;

  logic               clk = 1'b0;
  logic               arst_n;
  logic [NP*HW-1:0]   h_fifo_dout;
  logic [NP-1:0]      h_fifo_empty, h_fifo_rden;
  logic [NP*8-1:0]    b_fifo_dout;
  logic [NP-1:0]      b_fifo_empty, b_fifo_del, b_fifo_rden;
  logic [HW-1:0]      m_h_dout;
  logic               m_h_empty, m_h_rden;
  logic [7:0]         m_b_dout;
  logic               m_b_empty, m_b_del, m_b_rden;
  logic               grant_valid;
  logic [PW-1:0]      grant_port;

  always #5 clk = ~clk;

  ingress_frame_arbiter #(
    .NPORTS(NP), .HEADER_DWIDTH(HW), .CTRL_BIT(CB)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
    .b_fifo_dout(b_fifo_dout), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
    .b_fifo_rden(b_fifo_rden),
    .m_h_dout(m_h_dout), .m_h_empty(m_h_empty), .m_h_rden(m_h_rden),
    .m_b_dout(m_b_dout), .m_b_empty(m_b_empty), .m_b_del(m_b_del), .m_b_rden(m_b_rden),
    .grant_valid(grant_valid), .grant_port(grant_port)
  );

  typedef logic [HW-1:0] hdr_q_t[$];
  typedef logic [8:0]    body_q_t[$];
  hdr_q_t  hq[NP];
  body_q_t bq[NP];

  // Reference model state: who should hold the grant and the rotation pointer.
  logic exp_valid = 1'b0;
  int   exp_port  = 0;
  int   rr_m      = 0;
  int   cool      = 0;
  logic body_done = 1'b0;

  int checks = 0;
  int errors = 0;

  int   glog[$];
  logic prev_gv = 1'b0;
  logic seen_grant = 1'b0;
  int   gap = 0, min_gap = 1000, max_gap = 0;
  int   cnt_h2 = 0, cnt_b2 = 0;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int port, input int len, input bit ctrl);
    logic [HW-1:0] h;
    h = {$urandom(), $urandom(), $urandom(), $urandom()};
    h[CB] = ctrl;
    hq[port].push_back(h);
    for (int i = 0; i < len; i++) bq[port].push_back({(i == len - 1), 8'($urandom())});
  endtask

  task automatic drive_fifos();
    logic [8:0] bh;
    for (int i = 0; i < NP; i++) begin
      h_fifo_empty[i]       = (hq[i].size() == 0);
      h_fifo_dout[i*HW +: HW] = (hq[i].size() != 0) ? hq[i][0] : '0;
      b_fifo_empty[i]       = (bq[i].size() == 0);
      bh                    = (bq[i].size() != 0) ? bq[i][0] : '0;
      b_fifo_dout[i*8 +: 8] = bh[7:0];
      b_fifo_del[i]         = bh[8];
    end
  endtask

  // Winner by the arbitration rule: scan from rr_m, control frames first when enabled.
  function automatic int pick();
    logic [NP-1:0] rq, cq;
    for (int i = 0; i < NP; i++) begin
      rq[i] = (hq[i].size() != 0);
      cq[i] = rq[i] && hq[i][0][CB];
    end
`ifdef CTRL_PRIO_EN
    if (cq != 0) rq = cq;
`endif
    for (int k = 0; k < NP; k++) if (rq[(rr_m + k) % NP]) return (rr_m + k) % NP;
    return -1;
  endfunction

  function automatic bit hdr_pending();
    for (int i = 0; i < NP; i++) if (hq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive FIFOs, check outputs, act as consumer, then advance the model at the edge.
  task automatic cycle();
    int p;
    logic [NP-1:0] eh, eb;
    logic [8:0] bh;
    drive_fifos();
    p = exp_port;
    m_b_rden = 1'b0;
    m_h_rden = 1'b0;
    #1;
    chk("grant_valid", grant_valid, exp_valid);
    if (exp_valid) begin
      chk("grant_port", grant_port, p);
      chk("m_h_empty", m_h_empty, hq[p].size() == 0);
      chk("m_b_empty", m_b_empty, bq[p].size() == 0);
      if (hq[p].size() != 0) chk("m_h_dout", m_h_dout, hq[p][0]);
      if (bq[p].size() != 0) begin
        bh = bq[p][0];
        chk("m_b_dout", m_b_dout, bh[7:0]);
        chk("m_b_del", m_b_del, bh[8]);
      end
      if (!body_done && bq[p].size() != 0) m_b_rden = ($urandom_range(0, 3) != 0);
      else m_h_rden = 1'($urandom_range(0, 1));
    end else begin
      chk("idle_m_h_empty", m_h_empty, 1);
      chk("idle_m_b_empty", m_b_empty, 1);
      chk("idle_m_h_dout", m_h_dout, 0);
      chk("idle_m_b_dout", m_b_dout, 0);
      chk("idle_m_b_del", m_b_del, 0);
      m_b_rden = ($urandom_range(0, 7) == 0);
      m_h_rden = ($urandom_range(0, 7) == 0);
    end
    #1;
    eh = (exp_valid && m_h_rden) ? (NP'(1) << p) : '0;
    eb = (exp_valid && m_b_rden) ? (NP'(1) << p) : '0;
    chk("h_fifo_rden", h_fifo_rden, eh);
    chk("b_fifo_rden", b_fifo_rden, eb);
    if (h_fifo_rden[2]) cnt_h2++;
    if (b_fifo_rden[2]) cnt_b2++;
    if (grant_valid && !prev_gv) begin
      glog.push_back(int'(grant_port));
      if (seen_grant) begin
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
      end
      seen_grant = 1'b1;
      gap = 0;
    end else if (!grant_valid) begin
      gap++;
    end
    prev_gv = grant_valid;
    @(posedge clk);
    if (exp_valid) begin
      if (m_b_rden && bq[p].size() != 0) begin
        bh = bq[p].pop_front();
        if (bh[8]) body_done = 1'b1;
      end
      if (m_h_rden) begin
        void'(hq[p].pop_front());
        body_done = 1'b0;
        exp_valid = 1'b0;
        rr_m      = (p + 1) % NP;
        cool      = 1;
      end
    end else if (cool > 0) begin
      cool--;
    end else begin
      int w;
      w = pick();
      if (w >= 0) begin
        exp_valid = 1'b1;
        exp_port  = w;
      end
    end
    #1;
  endtask

  // Assert reset away from the clock edge with pops requested; outputs must go idle at once.
  task automatic do_reset();
    m_b_rden = 1'b1;
    m_h_rden = 1'b1;
    arst_n   = 1'b0;
    #1;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_h_fifo_rden", h_fifo_rden, 0);
    chk("rst_b_fifo_rden", b_fifo_rden, 0);
    chk("rst_m_h_empty", m_h_empty, 1);
    chk("rst_m_b_empty", m_b_empty, 1);
    exp_valid = 1'b0; cool = 0; rr_m = 0; body_done = 1'b0; prev_gv = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_grant_valid", grant_valid, 0);
      chk("rst_hold_grant_port", grant_port, 0);
    end
    m_b_rden = 1'b0;
    m_h_rden = 1'b0;
    arst_n   = 1'b1;
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((hdr_pending() || exp_valid || cool > 0) && n < bound) begin
      cycle();
      n++;
    end
    chk(tag, n < bound, 1);
    for (int i = 0; i < NP; i++) bq[i].delete();
  endtask

  task automatic clear_log();
    glog.delete();
    seen_grant = 1'b0; gap = 0; min_gap = 1000; max_gap = 0;
  endtask

  initial begin
    int n;
    int exp3[5];
    int exp5;
    exp3 = '{0, 1, 2, 3, 0};
    arst_n = 1'b0;
    m_b_rden = 1'b0;
    m_h_rden = 1'b0;
    drive_fifos();
    @(posedge clk); #1;
    do_reset();

    // Idle after reset: nothing requested, nothing granted or popped.
    repeat (20) cycle();

    // Single 60-byte frame on port 2: grant one cycle after the header appears.
    cnt_h2 = 0; cnt_b2 = 0;
    push_frame(2, 60, 1'b0);
    cycle();
    chk("t2_grant_valid", grant_valid, 1);
    chk("t2_grant_port", grant_port, 2);
    drain("t2_timeout", 1000);
    chk("t2_b_pops", cnt_b2, 60);
    chk("t2_h_pops", cnt_h2, 1);

    // All ports busy from rr_ptr=0: grants rotate 0,1,2,3,0 with two-cycle gaps.
    do_reset();
    clear_log();
    for (int i = 0; i < NP; i++) begin
      push_frame(i, 1 + int'($urandom_range(0, 5)), 1'b0);
      push_frame(i, 1 + int'($urandom_range(0, 5)), 1'b0);
    end
    n = 0;
    while (glog.size() < 5 && n < 600) begin cycle(); n++; end
    chk("t3_grant_count", glog.size() >= 5, 1);
    for (int i = 0; i < 5; i++) if (i < glog.size()) chk("t3_grant_order", glog[i], exp3[i]);
    chk("t3_min_gap", min_gap, 2);
    chk("t3_max_gap", max_gap, 2);
    drain("t3_timeout", 2000);

    // Port 3 arrives mid-frame of port 1: no pre-emption, port 3 is next.
    do_reset();
    clear_log();
    push_frame(1, 20, 1'b0);
    n = 0;
    while (!exp_valid && n < 10) begin cycle(); n++; end
    repeat (3) cycle();
    push_frame(3, 5, 1'b0);
    n = 0;
    while (glog.size() < 2 && n < 500) begin cycle(); n++; end
    chk("t4_grant_count", glog.size() >= 2, 1);
    if (glog.size() >= 2) begin
      chk("t4_first", glog[0], 1);
      chk("t4_second", glog[1], 3);
    end
    drain("t4_timeout", 1000);

    // Control-frame priority: port 3 carries the control bit.
    do_reset();
`ifdef CTRL_PRIO_EN
    exp5 = 3;
`else
    exp5 = 0;
`endif
    push_frame(0, 3, 1'b0);
    push_frame(1, 3, 1'b0);
    push_frame(3, 3, 1'b1);
    cycle();
    chk("t5_grant_valid", grant_valid, 1);
    chk("t5_grant_port", grant_port, exp5);
    drain("t5_timeout", 1000);

    // Reset mid-frame on port 1 (rr_ptr moved to 2 beforehand): pointer returns to 0.
    do_reset();
    push_frame(1, 4, 1'b0);
    drain("t6a_timeout", 500);
    push_frame(1, 30, 1'b0);
    n = 0;
    while (!exp_valid && n < 10) begin cycle(); n++; end
    repeat (4) cycle();
    do_reset();
    push_frame(2, 3, 1'b0);
    cycle();
    chk("t6_grant_valid", grant_valid, 1);
    chk("t6_grant_port", grant_port, 1);
    drain("t6_timeout", 1000);

    // Random traffic with mixed control frames.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int prt;
        prt = int'($urandom_range(0, NP - 1));
        if (hq[prt].size() < 4)
          push_frame(prt, 1 + int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      end
      cycle();
    end
    drain("rand_timeout", 4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
